// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Optional phase-sync input is enabled by defining CLK_DIV_PHASE_SYNC_EN.
package clk_div_pkg;

  // Channel output modes
  localparam logic MODE_TOGGLE = 1'b0;  // 50% square wave on o_clk
  localparam logic MODE_PULSE  = 1'b1;  // one-cycle o_tick only, o_clk held 0

  // Divide values for a 12 MHz sysclk (toggle-mode output frequency)
  localparam int unsigned DEF_DIV_1KHZ = 5999;
  localparam int unsigned DEF_DIV_1HZ  = 5_999_999;

  // Width of a channel address; a single channel still needs one address bit
  function automatic int unsigned ch_addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Per-channel connection between the clk_div_multi write decode and one
// clk_div_ch instance. The sync signal is only driven high when the design
// is built with CLK_DIV_PHASE_SYNC_EN; otherwise it is tied low.
//
// Handshake: wr is a one-cycle strobe with no back-pressure; wr_div/wr_mode
// are only meaningful in the cycle wr is 1. en and sync are level inputs
// sampled every sysclk edge. clk_o/tick/pend are registered channel outputs.
interface clk_div_multi_if #(
  parameter int CNT_W = 24
) ();

  logic             en;
  logic             wr;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic             sync;
  logic             clk_o;
  logic             tick;
  logic             pend;

  // Decode side drives configuration, reads channel outputs
  modport master (
    output en, wr, wr_div, wr_mode, sync,
    input  clk_o, tick, pend
  );

  // Channel side
  modport slave (
    input  en, wr, wr_div, wr_mode, sync,
    output clk_o, tick, pend
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow/active divide+mode registers and the
// toggle/pulse output logic. A new configuration is written into the shadow
// and copied into the active registers only at a terminal count (or at once
// when the channel is disabled), so the output never glitches mid-period.
// Phase sync (CLK_DIV_PHASE_SYNC_EN at the top) arrives on bus.sync.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               CNT_W    = 24,
  parameter logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEF_DIV_1KHZ),
  parameter bit               DEF_MODE = MODE_TOGGLE
) (
  input  logic            sysclk,
  input  logic            i_rst_n,
  clk_div_multi_if.slave  bus
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_act_div;
  logic [CNT_W-1:0] r_sh_div;
  logic             r_act_mode;
  logic             r_sh_mode;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic             w_sync;
  logic             w_tc;
  logic             w_apply;
  logic             w_keep_tgl;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clk_nxt;
  logic             w_pend_nxt;
  logic             w_tick_nxt;

  // Event decode: sync, terminal count, and whether the shadow is applied now
  always_comb begin
    w_sync     = bus.sync & bus.en;
    w_tc       = bus.en & (r_cnt == r_act_div);
    // Enabled channels apply at TC or sync; disabled channels apply at once
    w_apply    = r_pend & (w_sync | w_tc | ~bus.en);
    // Only a toggle->toggle apply keeps the running o_clk phase
    w_keep_tgl = (r_act_mode == MODE_TOGGLE) & (r_sh_mode == MODE_TOGGLE);
  end

  // Next-state for counter, divided clock, tick and pending flag
  always_comb begin
    w_cnt_nxt  = r_cnt + 1'b1;
    w_clk_nxt  = r_clk;
    w_tick_nxt = w_tc & ~w_sync;
    // A write in the apply cycle lands in the shadow and stays pending
    w_pend_nxt = bus.wr | (r_pend & ~w_apply);

    if (!bus.en || w_sync || w_tc) begin
      w_cnt_nxt = '0;
    end

    if (w_sync) begin
      w_clk_nxt = 1'b0;
    end else if (w_tc) begin
      if (w_apply) begin
        // Any mode change restarts o_clk from 0
        w_clk_nxt = w_keep_tgl & ~r_clk;
      end else if (r_act_mode == MODE_TOGGLE) begin
        w_clk_nxt = ~r_clk;
      end
    end else if (w_apply) begin
      // Disabled apply: hold level unless the mode changes
      w_clk_nxt = w_keep_tgl & r_clk;
    end
  end

  // State registers with asynchronous reset to the default configuration
  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_act_div  <= DEF_DIV;
      r_sh_div   <= DEF_DIV;
      r_act_mode <= DEF_MODE;
      r_sh_mode  <= DEF_MODE;
      r_pend     <= 1'b0;
      r_clk      <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_clk  <= w_clk_nxt;
      r_tick <= w_tick_nxt;
      r_pend <= w_pend_nxt;
      if (w_apply) begin
        r_act_div  <= r_sh_div;
        r_act_mode <= r_sh_mode;
      end
      if (bus.wr) begin
        r_sh_div  <= bus.wr_div;
        r_sh_mode <= bus.wr_mode;
      end
    end
  end

  assign bus.clk_o = r_clk;
  assign bus.tick  = r_tick;
  assign bus.pend  = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent clock-enable / divided-clock generators on sysclk.
// Top level decodes the configuration write to one channel and replicates
// clk_div_ch. Define CLK_DIV_PHASE_SYNC_EN to add the i_sync input that
// phase-aligns all enabled channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 24,
  parameter int unsigned DEF_DIV  = DEF_DIV_1KHZ,
  parameter bit          DEF_MODE = MODE_TOGGLE,
  localparam int         CH_W     = ch_addr_w(NUM_CH)
) (
  input  logic              sysclk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_wr,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_div,
  input  logic              i_wr_mode,
`ifdef CLK_DIV_PHASE_SYNC_EN
  input  logic              i_sync,
`endif
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pend
);

  logic w_sync;

`ifdef CLK_DIV_PHASE_SYNC_EN
  assign w_sync = i_sync;
`else
  // Channels free-run independently without the sync feature
  assign w_sync = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_multi_if #(.CNT_W(CNT_W)) u_bus ();

    // Write decode: addresses at or above NUM_CH match no channel
    assign u_bus.wr      = i_wr & (i_wr_ch == CH_W'(g));
    assign u_bus.wr_div  = i_wr_div;
    assign u_bus.wr_mode = i_wr_mode;
    assign u_bus.en      = i_en[g];
    assign u_bus.sync    = w_sync;

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (CNT_W'(DEF_DIV)),
      .DEF_MODE(DEF_MODE)
    ) u_ch (
      .sysclk (sysclk),
      .i_rst_n(i_rst_n),
      .bus    (u_bus.slave)
    );

    assign o_clk[g]  = u_bus.clk_o;
    assign o_tick[g] = u_bus.tick;
    assign o_pend[g] = u_bus.pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural model of each channel.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;

  logic              sysclk = 1'b0;
  logic              rst_n;
  logic [NUM_CH-1:0] i_en;
  logic              i_wr;
  logic [1:0]        i_wr_ch;
  logic [CNT_W-1:0]  i_wr_div;
  logic              i_wr_mode;
  logic              i_sync;
  logic [NUM_CH-1:0] o_clk;
  logic [NUM_CH-1:0] o_tick;
  logic [NUM_CH-1:0] o_pend;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Behavioural model state, one entry per channel
  int m_pos  [NUM_CH];
  int m_div  [NUM_CH];
  int m_sdiv [NUM_CH];
  bit m_mode [NUM_CH];
  bit m_smode[NUM_CH];
  bit m_pend [NUM_CH];
  bit m_clk  [NUM_CH];
  bit m_tick [NUM_CH];

  clk_div_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV_1KHZ),
    .DEF_MODE(MODE_TOGGLE)
  ) dut (
    .sysclk   (sysclk),
    .i_rst_n  (rst_n),
    .i_en     (i_en),
    .i_wr     (i_wr),
    .i_wr_ch  (i_wr_ch),
    .i_wr_div (i_wr_div),
    .i_wr_mode(i_wr_mode),
`ifdef CLK_DIV_PHASE_SYNC_EN
    .i_sync   (i_sync),
`endif
    .o_clk    (o_clk),
    .o_tick   (o_tick),
    .o_pend   (o_pend)
  );

  // Clock and watchdog
  always #5 sysclk = ~sysclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c]   = 0;
      m_div[c]   = DEF_DIV_1KHZ;
      m_sdiv[c]  = DEF_DIV_1KHZ;
      m_mode[c]  = MODE_TOGGLE;
      m_smode[c] = MODE_TOGGLE;
      m_pend[c]  = 1'b0;
      m_clk[c]   = 1'b0;
      m_tick[c]  = 1'b0;
    end
  endtask

  // One sysclk of every channel, phrased as the period/apply rules
  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit en, wr, sy, tc, do_apply;
      en = i_en[c];
      wr = i_wr && (int'(i_wr_ch) == c);
      sy = en && i_sync;
      tc = en && (m_pos[c] == m_div[c]);
      m_tick[c] = tc && !sy;
      if (sy) begin
        m_pos[c] = 0;
        m_clk[c] = 1'b0;
      end else if (!en) begin
        m_pos[c] = 0;
      end else if (tc) begin
        m_pos[c] = 0;
        if (m_mode[c] == MODE_TOGGLE) m_clk[c] = !m_clk[c];
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
      do_apply = m_pend[c] && (sy || tc || !en);
      if (do_apply) begin
        if (m_smode[c] != m_mode[c]) m_clk[c] = 1'b0;
        m_div[c]  = m_sdiv[c];
        m_mode[c] = m_smode[c];
        m_pend[c] = 1'b0;
      end
      if (wr) begin
        m_sdiv[c]  = int'(i_wr_div);
        m_smode[c] = i_wr_mode;
        m_pend[c]  = 1'b1;
      end
    end
  endtask

  function automatic logic [NUM_CH-1:0] mvec(input int sel);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (sel)
        0:       v[c] = m_clk[c];
        1:       v[c] = m_tick[c];
        default: v[c] = m_pend[c];
      endcase
    end
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge sysclk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Scoreboard compare: every cycle, 2 time units after the active edge
  initial begin
    forever begin
      @(posedge sysclk);
      #2;
      if (rst_n && chk_on) begin
        check("model_clk",  o_clk,  mvec(0));
        check("model_tick", o_tick, mvec(1));
        check("model_pend", o_pend, mvec(2));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #2;
    end
  endtask

  task automatic wait_tick(input int c, input int max_c, output int n);
    n = 0;
    do begin
      @(posedge sysclk);
      #2;
      n++;
    end while (o_tick[c] !== 1'b1 && n < max_c);
  endtask

  task automatic cfg_write(input int c, input int div, input bit mode);
    i_wr      = 1'b1;
    i_wr_ch   = 2'(c);
    i_wr_div  = CNT_W'(div);
    i_wr_mode = mode;
    step(1);
    i_wr      = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int t0, t1;
    rst_n = 1'b0; i_en = '0; i_wr = 1'b0; i_wr_ch = '0;
    i_wr_div = '0; i_wr_mode = 1'b0; i_sync = 1'b0;
    t0 = 0; t1 = 0;

    #12;
    check("rst_clk",  o_clk,  0);
    check("rst_tick", o_tick, 0);
    check("rst_pend", o_pend, 0);
    #10;
    rst_n  = 1'b1;
    i_en   = 4'b0001;
    chk_on = 1'b1;

    // Defaults: 1 kHz toggle on channel 0
    wait_tick(0, 7000, n);
    check("t1_first_tick", n, 6000);
    check("t1_clk_hi", o_clk[0], 1);
    wait_tick(0, 7000, n);
    check("t1_tick_period", n, 6000);
    check("t1_clk_lo", o_clk[0], 0);
    check("t1_others_idle", {o_clk[3:1], o_tick[3:1], o_pend}, 0);

    // Channel 1: N=3 pulse written while disabled
    cfg_write(1, 3, MODE_PULSE);
    check("t2_pend_set", o_pend[1], 1);
    step(1);
    check("t2_pend_pulse_clr", o_pend[1], 0);
    i_en = 4'b0011;
    wait_tick(1, 20, n);
    check("t2_first_tick", n, 4);
    wait_tick(1, 20, n);
    check("t2_tick_period", n, 4);
    check("t2_clk_zero", o_clk[1], 0);

    // Channel 0: run at N=9, then write N=4 when cnt=5
    i_en[0] = 1'b0;
    cfg_write(0, 9, MODE_TOGGLE);
    step(1);
    i_en[0] = 1'b1;
    wait_tick(0, 20, n);
    check("t3_restart_tick", n, 10);
    check("t3_clk_a", o_clk[0], 1);
    step(5);
    cfg_write(0, 4, MODE_TOGGLE);
    check("t3_pend_held", o_pend[0], 1);
    wait_tick(0, 20, n);
    check("t3_old_tc", n, 4);
    check("t3_pend_clr", o_pend[0], 0);
    check("t3_clk_b", o_clk[0], 0);
    wait_tick(0, 20, n);
    check("t3_new_period_a", n, 5);
    check("t3_clk_c", o_clk[0], 1);
    wait_tick(0, 20, n);
    check("t3_new_period_b", n, 5);
    check("t3_clk_d", o_clk[0], 0);

    // Channel 2: write coinciding with TC
    cfg_write(2, 6, MODE_TOGGLE);
    step(1);
    i_en[2] = 1'b1;
    wait_tick(2, 20, n);
    check("t4_first_tick", n, 7);
    step(6);
    cfg_write(2, 2, MODE_TOGGLE);
    check("t4_tick_at_wr", o_tick[2], 1);
    check("t4_pend_after_tc", o_pend[2], 1);
    wait_tick(2, 20, n);
    check("t4_old_n_kept", n, 7);
    check("t4_pend_clr", o_pend[2], 0);
    wait_tick(2, 20, n);
    check("t4_new_n", n, 3);

    // Channel 3: N=0 toggle
    cfg_write(3, 0, MODE_TOGGLE);
    step(1);
    i_en[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("t5_tick_const", o_tick[3], 1);
      check("t5_clk_alt", o_clk[3], (k % 2 == 0) ? 1 : 0);
    end

    // Short asynchronous reset pulse mid-count
    #1 rst_n = 1'b0;
    #2;
    check("t6_async_clk",  o_clk,  0);
    check("t6_async_tick", o_tick, 0);
    check("t6_async_pend", o_pend, 0);
    #1 rst_n = 1'b1;
    i_en = 4'b1111;
    wait_tick(0, 7000, n);
    check("t6_restart_tick", n, 6000);
    check("t6_all_ticks", o_tick, 4'b1111);
    check("t6_all_clk", o_clk, 4'b1111);

`ifdef CLK_DIV_PHASE_SYNC_EN
    // Phase sync: ch0 N=5, ch1 N=7
    i_en = '0;
    cfg_write(0, 5, MODE_TOGGLE);
    cfg_write(1, 7, MODE_TOGGLE);
    step(1);
    i_en = 4'b0011;
    step(3);
    i_sync = 1'b1;
    step(1);
    i_sync = 1'b0;
    check("t7_sync_clk", o_clk[1:0], 0);
    check("t7_sync_no_tick", o_tick[1:0], 0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (o_tick[0] && t0 == 0) t0 = k;
      if (o_tick[1] && t1 == 0) t1 = k;
    end
    check("t7_ch0_tick", t0, 6);
    check("t7_ch1_tick", t1, 8);
`endif

    chk_on = 1'b0;
    step(1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
